// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampled, majority-voted UART receiver with a valid/ready holding register.
// Optional break detection is enabled with macro UART_RX_BREAK_DET_EN. Rev 1.0
`default_nettype none

module uart_rx_os #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic [1:0]            parity_mode,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  err_frame,
  output logic                  err_parity,
  output logic                  err_overrun,
  output logic                  brk,
  output logic                  busy
);

  localparam int SW = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
`ifdef UART_RX_BREAK_DET_EN
    , S_WAIT = 3'd5
`endif
  } state_t;

  state_t                 state;
  logic                   sync1, sync2, prev;
  logic [DIV_WIDTH-1:0]   div_l, tick_cnt;
  logic [1:0]             mode_l;
  logic [SW-1:0]          s_cnt;
  logic                   v_a, v_b;
  logic [DATA_WIDTH-1:0]  shreg;
  logic [3:0]             bit_cnt;
  logic                   stop_cnt;
  logic                   par_bit;
  logic                   stop_bad;
`ifdef UART_RX_BREAK_DET_EN
  logic                   all_zero;
`endif

  logic start_det, tick, vote_now, end_bit, maj, par_en, par_x, par_bad, last_stop;

  assign start_det = prev & ~sync2 & (state == S_IDLE);
  assign tick      = (tick_cnt == div_l);
  assign vote_now  = tick && (s_cnt == SW'(OVERSAMPLE/2 + 1));
  assign end_bit   = tick && (s_cnt == SW'(OVERSAMPLE - 1));
  // The third sample is the live synchronised value at the vote tick.
  assign maj       = (v_a & v_b) | (v_a & sync2) | (v_b & sync2);
  assign par_en    = (mode_l == 2'b01) || (mode_l == 2'b10);
  assign par_x     = (^shreg) ^ par_bit;
  assign par_bad   = (mode_l == 2'b01) ? par_x : (mode_l == 2'b10) ? ~par_x : 1'b0;
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

`ifndef UART_RX_BREAK_DET_EN
  assign brk = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      prev        <= 1'b0;
      div_l       <= '0;
      tick_cnt    <= '0;
      mode_l      <= 2'b00;
      s_cnt       <= '0;
      v_a         <= 1'b0;
      v_b         <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      par_bit     <= 1'b0;
      stop_bad    <= 1'b0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
      busy        <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      all_zero    <= 1'b0;
      brk         <= 1'b0;
`endif
    end else begin
      sync1       <= rx;
      sync2       <= sync1;
      prev        <= sync2;
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk         <= 1'b0;
`endif
      if (m_valid && m_ready) m_valid <= 1'b0;

      if (start_det || tick) tick_cnt <= '0;
      else                   tick_cnt <= tick_cnt + 1'b1;

      if (start_det)    s_cnt <= '0;
      else if (end_bit) s_cnt <= '0;
      else if (tick)    s_cnt <= s_cnt + 1'b1;

      if (tick && s_cnt == SW'(OVERSAMPLE/2 - 1)) v_a <= sync2;
      if (tick && s_cnt == SW'(OVERSAMPLE/2))     v_b <= sync2;

      case (state)
        S_IDLE: begin
          if (start_det) begin
            state    <= S_START;
            busy     <= 1'b1;
            div_l    <= baud_div;
            mode_l   <= parity_mode;
            stop_bad <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            all_zero <= 1'b1;
`endif
          end
        end
        S_START: begin
          if (vote_now && maj) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (end_bit) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (vote_now) begin
            shreg <= {maj, shreg[DATA_WIDTH-1:1]};
`ifdef UART_RX_BREAK_DET_EN
            all_zero <= all_zero & ~maj;
`endif
          end
          if (end_bit) begin
            if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
              state    <= par_en ? S_PARITY : S_STOP;
              stop_cnt <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (vote_now) begin
            par_bit <= maj;
`ifdef UART_RX_BREAK_DET_EN
            all_zero <= all_zero & ~maj;
`endif
          end
          if (end_bit) begin
            state    <= S_STOP;
            stop_cnt <= 1'b0;
          end
        end
        S_STOP: begin
          // Commit on the last stop vote so a following start edge up to half a bit early is still caught.
          if (vote_now && last_stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            if (all_zero && (stop_cnt || !maj)) begin
              brk   <= 1'b1;
              state <= S_WAIT;
              busy  <= 1'b1;
            end else
`endif
            if (stop_bad || !maj) begin
              err_frame <= 1'b1;
            end else if (par_bad) begin
              err_parity <= 1'b1;
            end else if (m_valid && !m_ready) begin
              err_overrun <= 1'b1;
            end else begin
              m_data  <= shreg;
              m_valid <= 1'b1;
            end
          end else if (vote_now) begin
            stop_bad <= stop_bad | ~maj;
`ifdef UART_RX_BREAK_DET_EN
            if (!stop_cnt) all_zero <= all_zero & ~maj;
`endif
          end
          if (end_bit && !last_stop) stop_cnt <= stop_cnt + 1'b1;
        end
`ifdef UART_RX_BREAK_DET_EN
        S_WAIT: begin
          if (tick && sync2) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Next-generation UART receiver with oversampled, majority-voted bit recovery. Baud rate and parity mode are set at run time, and data width and stop-bit count are set by parameter. Received words are delivered on a valid/ready stream with a one-word holding register, plus per-frame error pulses. The block sits between the pad synchroniser domain and the command/packet parser, replacing the single-sample receiver.

Parameters:
DATA_WIDTH, 8, data bits per frame, legal 5..9, sent LSB first
STOP_BITS, 1, stop bits checked per frame, legal 1..2
OVERSAMPLE, 16, sample ticks per bit, legal even and >= 8
DIV_WIDTH, 16, width of baud_div

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
rx  in  1  asynchronous serial line, idle high
baud_div  in  DIV_WIDTH  sample tick every baud_div+1 clk cycles
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
m_data  out  DATA_WIDTH  received word
m_valid  out  1  m_data valid
m_ready  in  1  consumer accepts m_data
err_frame  out  1  1-cycle pulse: a stop bit sampled low
err_parity  out  1  1-cycle pulse: parity mismatch
err_overrun  out  1  1-cycle pulse: good word dropped, holding register full
brk  out  1  1-cycle pulse: break detected (see Optional Feature)
busy  out  1  high while FSM not IDLE

Behaviour:
- Reset (rst_n=0 at clk edge): FSM=IDLE; m_data=0; m_valid, all err_*, brk, busy=0; synchroniser flops=1; edge-detect prev flop=0, so no start is detected until rx has been seen high after reset.
- rx passes through a 2-flop synchroniser. Start = synced prev 1, current 0, while in IDLE.
- Tick counter: counts 0..baud_div and emits a tick on wrap. It clears on start detection. baud_div=0 gives a tick every clk.
- baud_div and parity_mode are latched at start detection. Changes mid-frame have no effect.
- Sample counter s = 0..OVERSAMPLE-1 per bit. Bit value = majority of samples at s = OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
- FSM states:
  - IDLE -> START on start detection.
  - START: voted value 1 -> IDLE (false start, no error, no pulse). Otherwise at end of bit -> DATA.
  - DATA: shift in DATA_WIDTH bits LSB first. Then go to PARITY if the latched mode is 01 or 10, else to STOP.
  - PARITY: even requires XOR(data, parity bit)=0; odd requires 1.
  - STOP: check STOP_BITS bits. After the vote of the last stop bit (not at end of bit), commit and go to IDLE, allowing back-to-back frames with up to half a bit of skew.
- Commit priority, single cycle:
  - Any stop bit 0 -> err_frame pulse, word dropped.
  - Else parity bad -> err_parity pulse, word dropped.
  - Else, if m_valid=1 and m_ready=0 -> err_overrun pulse, new word dropped, m_data unchanged.
  - Else m_data <= word, m_valid <= 1.
  - Frame and parity errors on the same frame: only err_frame pulses.
- Handshake:
  - Transfer occurs when m_valid and m_ready are both high; m_valid then clears next cycle unless a commit occurs in the same cycle.
  - Commit coinciding with a transfer loads the new word and keeps m_valid=1, with no overrun.
  - m_data is stable while m_valid=1 and m_ready=0.
- Latency: m_valid rises 1 clk after the last stop-bit vote. For baud_div=3, OVERSAMPLE=16, 8N1, that is about 9.5 bit-times (~608 clk) after the start edge.
- Reset mid-frame aborts the frame with no error pulse and no m_valid.

Optional Feature:
Macro UART_RX_BREAK_DET_EN.
- Defined: a frame whose start, all data bits, parity bit (if any) and first stop bit all vote 0 produces a brk pulse instead of err_frame; no word is delivered. The FSM then holds in a WAIT_IDLE state until one voted-high sample tick, then returns to IDLE.
- Not defined: such a frame is an ordinary framing error. brk is tied to 0, the port is kept, and there is no WAIT_IDLE state.

Test Plan:
- baud_div=3, mode 00, send 0xA5 8N1 -> m_valid ~608 clk after start edge, m_data=0xA5, no error pulses.
- Mode 01, send 0x37 with parity bit 0 (correct is 1) -> err_parity pulse, m_valid stays 0. Then send 0x37 with parity 1 -> m_data=0x37.
- rx low for 8 clk (2 ticks), then high -> no pulses, busy returns to 0 within one bit-time, FSM IDLE.
- m_ready=0, send 0x11 then 0x22 -> m_data=0x11, err_overrun pulse at second commit. Then m_ready=1 for 1 clk -> m_valid=0.
- Send 0x00 with one tick-wide high glitch on sample s=8 of bit 3 -> m_data=0x00. Glitch covering samples 7..9 -> m_data=0x08.
- Send 0x5A with stop bit 0 -> err_frame, no m_valid. rx held low 12 bit-times -> brk pulse if UART_RX_BREAK_DET_EN, else err_frame. In both cases no m_valid, and recovery occurs after rx goes high.
